// File: rtl/mld_7_4_pkg.sv
// Shared constants and types for the (7,4) cyclic serial encoder.
//   N, K, P     : code length, message length, parity length
//   G_POLY      : generator g(x) = 1 + x + x^3, bit i = coefficient of x^i
//   GAP_CNT_W   : width of the shared frame/gap counter (covers 0..15)
//   enc_state_e : encoder FSM states
package mld_7_4_pkg;

    localparam int unsigned N         = 7;
    localparam int unsigned K         = 4;
    localparam int unsigned P         = 3;
    localparam logic [3:0]  G_POLY    = 4'b1011;
    localparam int unsigned GAP_CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        MSG,
        PARITY,
        GAP
    } enc_state_e;

endpackage

// File: rtl/cyclic_parity_lfsr_3.sv
// Three-stage division register for g(x) = 1 + x + x^3.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   clear       : start a new codeword (register treated as 000 this cycle)
//   shift_in_en : divide by one more message bit (din)
//   out_en      : shift the remainder left by one to unload the next parity bit
//   din         : message bit being divided in
//   parity_bit  : current top stage r2 (next parity bit to emit)
module cyclic_parity_lfsr_3
    import mld_7_4_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic shift_in_en,
    input  logic out_en,
    input  logic din,
    output logic parity_bit
);

    logic [P-1:0] r_q;
    logic [P-1:0] r_d;
    logic [P-1:0] base;
    logic         fb;

    always_comb begin
        // clear and shift_in_en may arrive together on the accept cycle:
        // the first message bit is divided into an already-cleared register.
        base = clear ? '0 : r_q;
        r_d  = base;
        fb   = din ^ base[P-1];
        if (shift_in_en) begin
            r_d = {base[1] ^ (fb & G_POLY[2]),
                   base[0] ^ (fb & G_POLY[1]),
                   fb & G_POLY[0]};
        end else if (out_en) begin
            r_d = {base[P-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_q <= '0;
        end else begin
            r_q <= r_d;
        end
    end

    assign parity_bit = r_q[P-1];

endmodule

// File: rtl/mld_7_4_serial_encoder.sv
// Systematic (7,4) cyclic encoder, g(x) = 1 + x + x^3, serial MSB-first output.
// Accepts a 4-bit message on a valid/ready handshake, emits c6..c0
// (m3,m2,m1,m0,p2,p1,p0) with load high, then GAP_CYCLES idle cycles.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   msg_in      : message m3..m0, latched at accept
//   msg_valid   : message offered
//   msg_ready   : encoder idle and able to accept
//   bit_stream  : registered serial codeword bit
//   load        : high while bit_stream carries a codeword bit
//   frame_start : one-cycle pulse coincident with c6
//   busy        : FSM not in IDLE
// Optional build macro MLD_ENCODER_ERROR_INJECT_EN adds inject_en / inject_pos
// (sampled at accept) to invert emitted bit c[inject_pos]; 7 injects nothing.
module mld_7_4_serial_encoder
    import mld_7_4_pkg::*;
#(
    parameter int unsigned GAP_CYCLES = 7
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [K-1:0] msg_in,
    input  logic         msg_valid,
`ifdef MLD_ENCODER_ERROR_INJECT_EN
    input  logic         inject_en,
    input  logic [2:0]   inject_pos,
`endif
    output logic         msg_ready,
    output logic         bit_stream,
    output logic         load,
    output logic         frame_start,
    output logic         busy
);

    localparam logic [GAP_CNT_W-1:0] GAP_LAST =
        GAP_CNT_W'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);

    enc_state_e           state_q, state_d;
    logic [GAP_CNT_W-1:0] cnt_q, cnt_d;
    logic [K-1:0]         msg_q, msg_d;
    logic                 bit_q, bit_d;
    logic                 load_q, load_d;
    logic                 fs_q, fs_d;

    logic                 lfsr_clear, lfsr_shift_in, lfsr_out_en, lfsr_din;
    logic                 parity_bit;
    logic                 raw_bit;
    logic [2:0]           idx;
    logic                 flip;

`ifdef MLD_ENCODER_ERROR_INJECT_EN
    logic                 inj_en_q, inj_en_d;
    logic [2:0]           inj_pos_q, inj_pos_d;
`endif

    cyclic_parity_lfsr_3 u_lfsr (
        .clk         (clk),
        .reset       (reset),
        .clear       (lfsr_clear),
        .shift_in_en (lfsr_shift_in),
        .out_en      (lfsr_out_en),
        .din         (lfsr_din),
        .parity_bit  (parity_bit)
    );

    // Outputs are registered, so each branch computes the bit that will be
    // on bit_stream next cycle; the LFSR absorbs a message bit on the same
    // edge that registers it, leaving the full remainder ready for p2.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        msg_d         = msg_q;
        raw_bit       = 1'b0;
        load_d        = 1'b0;
        fs_d          = 1'b0;
        idx           = '0;
        lfsr_clear    = 1'b0;
        lfsr_shift_in = 1'b0;
        lfsr_out_en   = 1'b0;
        lfsr_din      = 1'b0;
`ifdef MLD_ENCODER_ERROR_INJECT_EN
        inj_en_d      = inj_en_q;
        inj_pos_d     = inj_pos_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (msg_valid) begin
                    state_d       = MSG;
                    cnt_d         = '0;
                    msg_d         = msg_in;
                    raw_bit       = msg_in[K-1];
                    load_d        = 1'b1;
                    fs_d          = 1'b1;
                    idx           = 3'(N - 1);
                    lfsr_clear    = 1'b1;
                    lfsr_shift_in = 1'b1;
                    lfsr_din      = msg_in[K-1];
`ifdef MLD_ENCODER_ERROR_INJECT_EN
                    inj_en_d      = inject_en;
                    inj_pos_d     = inject_pos;
`endif
                end
            end
            MSG: begin
                load_d = 1'b1;
                if (cnt_q == GAP_CNT_W'(K - 1)) begin
                    state_d     = PARITY;
                    cnt_d       = '0;
                    raw_bit     = parity_bit;
                    idx         = 3'(P - 1);
                    lfsr_out_en = 1'b1;
                end else begin
                    cnt_d         = cnt_q + 1'b1;
                    msg_d         = {msg_q[K-2:0], 1'b0};
                    raw_bit       = msg_q[K-2];
                    idx           = 3'(N - 2) - cnt_q[2:0];
                    lfsr_shift_in = 1'b1;
                    lfsr_din      = msg_q[K-2];
                end
            end
            PARITY: begin
                if (cnt_q == GAP_CNT_W'(P - 1)) begin
                    cnt_d   = '0;
                    state_d = (GAP_CYCLES == 0) ? IDLE : GAP;
                end else begin
                    cnt_d       = cnt_q + 1'b1;
                    load_d      = 1'b1;
                    raw_bit     = parity_bit;
                    idx         = 3'(P - 2) - cnt_q[2:0];
                    lfsr_out_en = 1'b1;
                end
            end
            GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

`ifdef MLD_ENCODER_ERROR_INJECT_EN
        flip = load_d && inj_en_d && (inj_pos_d == idx);
`else
        flip = 1'b0;
`endif
        bit_d = raw_bit ^ flip;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            msg_q     <= '0;
            bit_q     <= 1'b0;
            load_q    <= 1'b0;
            fs_q      <= 1'b0;
`ifdef MLD_ENCODER_ERROR_INJECT_EN
            inj_en_q  <= 1'b0;
            inj_pos_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            msg_q     <= msg_d;
            bit_q     <= bit_d;
            load_q    <= load_d;
            fs_q      <= fs_d;
`ifdef MLD_ENCODER_ERROR_INJECT_EN
            inj_en_q  <= inj_en_d;
            inj_pos_q <= inj_pos_d;
`endif
        end
    end

    assign msg_ready   = !reset && (state_q == IDLE);
    assign busy        = (state_q != IDLE);
    assign bit_stream  = bit_q;
    assign load        = load_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_mld_7_4_serial_encoder.sv
// Self-checking bench for mld_7_4_serial_encoder (default build, no injection).
// Two instances share inputs: dut_a with GAP_CYCLES=7, dut_b with GAP_CYCLES=0.
// Reference codewords come from polynomial long division by g(x)=1+x+x^3.
module tb_mld_7_4_serial_encoder;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] msg_in = '0;
    logic       msg_valid = 1'b0;

    logic a_ready, a_bit, a_load, a_fs, a_busy;
    logic b_ready, b_bit, b_load, b_fs, b_busy;

    int unsigned passed = 0;
    int unsigned total  = 0;

    always #5 clk = ~clk;

    mld_7_4_serial_encoder #(.GAP_CYCLES(7)) dut_a (
        .clk         (clk),
        .reset       (reset),
        .msg_in      (msg_in),
        .msg_valid   (msg_valid),
        .msg_ready   (a_ready),
        .bit_stream  (a_bit),
        .load        (a_load),
        .frame_start (a_fs),
        .busy        (a_busy)
    );

    mld_7_4_serial_encoder #(.GAP_CYCLES(0)) dut_b (
        .clk         (clk),
        .reset       (reset),
        .msg_in      (msg_in),
        .msg_valid   (msg_valid),
        .msg_ready   (b_ready),
        .bit_stream  (b_bit),
        .load        (b_load),
        .frame_start (b_fs),
        .busy        (b_busy)
    );

    // Remainder of a 7-bit polynomial (bit i = coeff of x^i) modulo g(x).
    function automatic logic [2:0] syndrome(input logic [6:0] c);
        int unsigned r = c;
        for (int i = 6; i >= 3; i--) begin
            if (r[i]) r = r ^ (32'd11 << (i - 3));
        end
        return 3'(r);
    endfunction

    function automatic logic [6:0] encode(input logic [3:0] m);
        return {m, syndrome({m, 3'b000})};
    endfunction

    // {bit_stream, load, frame_start, busy, msg_ready}
    function automatic logic [4:0] obs(input bit sel);
        return sel ? {b_bit, b_load, b_fs, b_busy, b_ready}
                   : {a_bit, a_load, a_fs, a_busy, a_ready};
    endfunction

    // Sends one message to dut_a and records 15 cycles of outputs, oldest
    // cycle in bit 14. msg_in is scrambled right after the accept.
    task automatic run_frame(input logic [3:0] m, output logic [14:0] bits,
                             output logic [14:0] loads, output logic [14:0] fss,
                             output logic [14:0] rdys, output bit timeout);
        int unsigned w = 0;
        bits = '0; loads = '0; fss = '0; rdys = '0; timeout = 1'b0;
        while (!a_ready && w < 40) begin
            @(negedge clk);
            w++;
        end
        if (!a_ready) begin
            timeout = 1'b1;
            return;
        end
        msg_in = m;
        msg_valid = 1'b1;
        @(negedge clk);
        msg_valid = 1'b0;
        msg_in = ~m;
        for (int i = 0; i < 15; i++) begin
            bits[14-i]  = a_bit;
            loads[14-i] = a_load;
            fss[14-i]   = a_fs;
            rdys[14-i]  = a_ready;
            if (i < 14) @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        msg_valid = 1'b1;
        msg_in = 4'hF;
        @(negedge clk);
        @(negedge clk);
        total++;
        if ({obs(0), obs(1)} !== 10'b0) $display("FAIL reset_hold: got %b expected %b", {obs(0), obs(1)}, 10'b0);
        else passed++;
        reset = 1'b0;
        msg_valid = 1'b0;
        #1;
        total++;
        if ({obs(0), obs(1)} !== 10'b00001_00001) $display("FAIL reset_release: got %b expected %b", {obs(0), obs(1)}, 10'b00001_00001);
        else passed++;
        @(negedge clk);
        total++;
        if ({obs(0), obs(1)} !== 10'b00001_00001) $display("FAIL reset_no_accept: got %b expected %b", {obs(0), obs(1)}, 10'b00001_00001);
        else passed++;
    endtask

    task automatic test_known_vectors();
        logic [3:0]  msgs [3] = '{4'b1000, 4'b0001, 4'b1011};
        logic [6:0]  words[3] = '{7'b1000101, 7'b0001011, 7'b1011000};
        logic [14:0] bits, loads, fss, rdys;
        bit          to;
        for (int k = 0; k < 3; k++) begin
            run_frame(msgs[k], bits, loads, fss, rdys, to);
            total++;
            if (to) $display("FAIL known_timeout: msg %b never accepted", msgs[k]);
            else passed++;
            total++;
            if (bits !== {words[k], 8'b0}) $display("FAIL known_bits msg %b: got %b expected %b", msgs[k], bits, {words[k], 8'b0});
            else passed++;
            total++;
            if (loads !== 15'b111_1111_0000_0000) $display("FAIL known_load msg %b: got %b expected %b", msgs[k], loads, 15'b111_1111_0000_0000);
            else passed++;
            total++;
            if (fss !== 15'b100_0000_0000_0000) $display("FAIL known_frame_start msg %b: got %b expected %b", msgs[k], fss, 15'b100_0000_0000_0000);
            else passed++;
            total++;
            if (rdys !== 15'b000_0000_0000_0001) $display("FAIL known_ready msg %b: got %b expected %b", msgs[k], rdys, 15'b000_0000_0000_0001);
            else passed++;
        end
    endtask

    task automatic test_sweep();
        logic [3:0]  order[16];
        logic [3:0]  t;
        logic [14:0] bits, loads, fss, rdys;
        bit          to;
        int unsigned j;
        for (int i = 0; i < 16; i++) order[i] = 4'(i);
        for (int i = 15; i > 0; i--) begin
            j = $urandom_range(i, 0);
            t = order[i]; order[i] = order[j]; order[j] = t;
        end
        for (int i = 0; i < 16; i++) begin
            run_frame(order[i], bits, loads, fss, rdys, to);
            total++;
            if (to || bits[14:8] !== encode(order[i]))
                $display("FAIL sweep_word msg %b: got %b expected %b (timeout %0d)", order[i], bits[14:8], encode(order[i]), to);
            else passed++;
            total++;
            if (syndrome(bits[14:8]) !== 3'b000)
                $display("FAIL sweep_syndrome msg %b: got %b expected %b", order[i], syndrome(bits[14:8]), 3'b000);
            else passed++;
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [3:0]  m  = 4'($urandom);
        logic [3:0]  m2 = 4'($urandom);
        logic [14:0] bits, loads, fss, rdys;
        int unsigned w = 0;
        bit          to;
        while (!a_ready && w < 40) begin
            @(negedge clk);
            w++;
        end
        msg_in = m;
        msg_valid = 1'b1;
        @(negedge clk);
        msg_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        total++;
        if ({a_load, a_busy} !== 2'b11) $display("FAIL midreset_in_frame: got %b expected %b", {a_load, a_busy}, 2'b11);
        else passed++;
        reset = 1'b1;
        @(negedge clk);
        total++;
        if (obs(0) !== 5'b00000) $display("FAIL midreset_during: got %b expected %b", obs(0), 5'b00000);
        else passed++;
        reset = 1'b0;
        #1;
        total++;
        if (obs(0) !== 5'b00001) $display("FAIL midreset_after: got %b expected %b", obs(0), 5'b00001);
        else passed++;
        run_frame(m2, bits, loads, fss, rdys, to);
        total++;
        if (to || bits !== {encode(m2), 8'b0})
            $display("FAIL midreset_next_frame msg %b: got %b expected %b (timeout %0d)", m2, bits, {encode(m2), 8'b0}, to);
        else passed++;
    endtask

    // msg_valid held high with msg_in changing every cycle; accepts must be
    // exactly sp cycles apart and each frame must encode the accepted message.
    task automatic test_back_to_back(input bit sel, input int unsigned sp);
        logic        q_bits[$];
        logic [3:0]  acc_msg[$];
        int unsigned acc_cyc[$];
        logic [6:0]  cw;
        logic [4:0]  o;
        int unsigned fs_n = 0, bad = 0, w = 0;
        o = obs(sel);
        while (!o[0] && w < 40) begin
            @(negedge clk);
            o = obs(sel);
            w++;
        end
        msg_valid = 1'b1;
        for (int unsigned i = 0; i < 3 * sp + 20; i++) begin
            if (i == 3 * sp) msg_valid = 1'b0;
            msg_in = 4'($urandom);
            o = obs(sel);
            if (o[3]) q_bits.push_back(o[4]);
            if (o[2]) fs_n++;
            if (o[0] && msg_valid) begin
                acc_msg.push_back(msg_in);
                acc_cyc.push_back(i);
            end
            @(negedge clk);
        end
        msg_valid = 1'b0;
        total++;
        if (acc_cyc.size() != 3) $display("FAIL b2b_accepts gap%0d: got %0d expected %0d", sp, acc_cyc.size(), 3);
        else passed++;
        for (int k = 1; k < acc_cyc.size(); k++) begin
            if (acc_cyc[k] - acc_cyc[k-1] != sp) bad++;
        end
        total++;
        if (bad != 0 || acc_cyc.size() < 2)
            $display("FAIL b2b_spacing gap%0d: got %0d wrong spacings of %0d accepts expected spacing %0d", sp, bad, acc_cyc.size(), sp);
        else passed++;
        bad = 0;
        if (q_bits.size() != 7 * acc_msg.size()) bad++;
        else begin
            for (int k = 0; k < acc_msg.size(); k++) begin
                cw = encode(acc_msg[k]);
                for (int b = 0; b < 7; b++) begin
                    if (q_bits[k*7 + b] !== cw[6-b]) bad++;
                end
            end
        end
        total++;
        if (bad != 0) $display("FAIL b2b_bits gap%0d: got %0d bad bits (%0d collected) expected 0 (%0d)", sp, bad, q_bits.size(), 7 * acc_msg.size());
        else passed++;
        total++;
        if (fs_n != 3) $display("FAIL b2b_frame_start gap%0d: got %0d expected %0d", sp, fs_n, 3);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_known_vectors();
        test_sweep();
        test_reset_mid_frame();
        test_back_to_back(1'b0, 15);
        test_back_to_back(1'b1, 8);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
